// File: rtl/bresenham_pkg.sv
// ============================================================================
// Module      : bresenham_pkg
// Description : Shared widths, FSM state type and arithmetic typedefs for the
//               Bresenham line rasterizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bresenham_pkg;

    localparam int COORD_W   = 8;
    localparam int MAX_PTS   = 260;
    localparam int ENTRY_W   = 2 * COORD_W;
    localparam int BUF_W     = MAX_PTS * ENTRY_W;
    localparam int BUF_IDX_W = $clog2(BUF_W);
    localparam int IDX_W     = $clog2(MAX_PTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } bresenham_state_t;

    typedef logic [COORD_W-1:0]        coord_t;
    // Running error term: spans dy..dx plus one extra step of headroom
    typedef logic signed [COORD_W+1:0] err_t;
    // Signed axis delta: +|dx| or -|dy|
    typedef logic signed [COORD_W:0]   delta_t;

endpackage

`default_nettype wire

// File: rtl/bresenham_step.sv
// ============================================================================
// Module      : bresenham_step
// Description : One combinational Bresenham iteration. Both axis decisions
//               are taken from the incoming error term and applied together.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bresenham_step
    import bresenham_pkg::*;
(
    input  err_t   err_i,
    input  delta_t dx_i,    // +|x1-x0|
    input  delta_t dy_i,    // -|y1-y0|
    input  logic   sx_i,    // 1: x steps by -1, 0: x steps by +1
    input  logic   sy_i,    // 1: y steps by -1, 0: y steps by +1
    input  coord_t x_i,
    input  coord_t y_i,
    output err_t   err_o,
    output coord_t x_o,
    output coord_t y_o
);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_w;
    logic signed [COORD_W+2:0] dy_w;
    logic signed [COORD_W+2:0] acc;

    // Compute the next error and pixel from the pre-update error term
    always_comb begin
        e2    = {err_i, 1'b0};
        dx_w  = {{2{dx_i[COORD_W]}}, dx_i};
        dy_w  = {{2{dy_i[COORD_W]}}, dy_i};
        acc   = {err_i[COORD_W+1], err_i};
        x_o   = x_i;
        y_o   = y_i;
        if (e2 >= dy_w) begin
            acc = acc + dy_w;
            x_o = sx_i ? (x_i - coord_t'(1)) : (x_i + coord_t'(1));
        end
        if (e2 <= dx_w) begin
            acc = acc + dx_w;
            y_o = sy_i ? (y_i - coord_t'(1)) : (y_i + coord_t'(1));
        end
        err_o = acc[COORD_W+1:0];
    end

endmodule

`default_nettype wire

// File: rtl/bresenham.sv
// ============================================================================
// Module      : bresenham
// Description : Bresenham line rasterizer, one pixel per clock in all eight
//               octants, every pixel captured in a flat packed line buffer.
//               Optional macro BRESENHAM_PIXEL_VALID_EN adds a pixel_valid
//               output marking the cycles where x/y is being written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bresenham
    import bresenham_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               start,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [BUF_W-1:0]   line_buffer,
    output logic               done
`ifdef BRESENHAM_PIXEL_VALID_EN
    ,
    output logic               pixel_valid
`endif
);

    bresenham_state_t     state_q;
    coord_t               x0_q, y0_q, x1_q, y1_q;
    coord_t               x_q, y_q;
    delta_t               dx_q, dy_q;
    err_t                 err_q;
    logic                 sx_q, sy_q;
    logic [IDX_W-1:0]     n_q;
    logic [BUF_W-1:0]     line_buffer_q;
    logic                 done_q;
`ifdef BRESENHAM_PIXEL_VALID_EN
    logic                 pixel_valid_q;
`endif

    coord_t               abs_dx, abs_dy;
    delta_t               init_dx_d, init_dy_d;
    err_t                 init_err_d;
    err_t                 err_d;
    coord_t               x_d, y_d;
    logic [BUF_IDX_W-1:0] wr_base;

    // Set-up terms derived from the latched endpoints, consumed in INIT
    always_comb begin
        abs_dx     = (x1_q > x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        abs_dy     = (y1_q > y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        init_dx_d  = delta_t'({1'b0, abs_dx});
        init_dy_d  = -delta_t'({1'b0, abs_dy});
        init_err_d = {init_dx_d[COORD_W], init_dx_d} + {init_dy_d[COORD_W], init_dy_d};
        wr_base    = BUF_IDX_W'(n_q) * BUF_IDX_W'(ENTRY_W);
    end

    bresenham_step u_step (
        .err_i (err_q),
        .dx_i  (dx_q),
        .dy_i  (dy_q),
        .sx_i  (sx_q),
        .sy_i  (sy_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .err_o (err_d),
        .x_o   (x_d),
        .y_o   (y_d)
    );

    // Control FSM with all datapath registers and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            x0_q          <= '0;
            y0_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            err_q         <= '0;
            sx_q          <= 1'b0;
            sy_q          <= 1'b0;
            n_q           <= '0;
            line_buffer_q <= '0;
            done_q        <= 1'b0;
`ifdef BRESENHAM_PIXEL_VALID_EN
            pixel_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        x0_q          <= x0;
                        y0_q          <= y0;
                        x1_q          <= x1;
                        y1_q          <= y1;
                        line_buffer_q <= '0;
                        done_q        <= 1'b0;
                        n_q           <= '0;
                        state_q       <= INIT;
                    end else if (state_q == DONE) begin
                        done_q <= 1'b1;
                    end
                end
                INIT: begin
                    dx_q    <= init_dx_d;
                    dy_q    <= init_dy_d;
                    err_q   <= init_err_d;
                    sx_q    <= !(x0_q < x1_q);
                    sy_q    <= !(y0_q < y1_q);
                    x_q     <= x0_q;
                    y_q     <= y0_q;
                    state_q <= DRAW;
`ifdef BRESENHAM_PIXEL_VALID_EN
                    pixel_valid_q <= 1'b1;
`endif
                end
                DRAW: begin
                    line_buffer_q[wr_base +: ENTRY_W] <= {x_q, y_q};
                    n_q <= n_q + IDX_W'(1);
                    if ((x_q == x1_q) && (y_q == y1_q)) begin
                        // Endpoint written: x/y keep the final pixel
                        state_q <= DONE;
`ifdef BRESENHAM_PIXEL_VALID_EN
                        pixel_valid_q <= 1'b0;
`endif
                    end else begin
                        err_q <= err_d;
                        x_q   <= x_d;
                        y_q   <= y_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign line_buffer = line_buffer_q;
    assign done        = done_q;
`ifdef BRESENHAM_PIXEL_VALID_EN
    assign pixel_valid = pixel_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bresenham.sv
// ============================================================================
// Module      : tb_bresenham
// Description : Self-checking bench for the Bresenham rasterizer: directed
//               lines, a per-cycle reference model and literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bresenham;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   tx0 = '0, ty0 = '0, tx1 = '0, ty1 = '0;
    logic [7:0]   x, y;
    logic [4159:0] lb;
    logic         done;
`ifdef BRESENHAM_PIXEL_VALID_EN
    logic         pv;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0]   mpts [256];
    int            mn = 0;
    int            mstate = 0;
    int            k = 0;
    int            nw;
    logic [4159:0] eb;

    always #5 clk = ~clk;

    bresenham dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .x0          (tx0),
        .y0          (ty0),
        .x1          (tx1),
        .y1          (ty1),
        .start       (start),
        .x           (x),
        .y           (y),
        .line_buffer (lb),
        .done        (done)
`ifdef BRESENHAM_PIXEL_VALID_EN
        ,
        .pixel_valid (pv)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkbuf(input string nm, input logic [4159:0] act, input logic [4159:0] exp);
        int bad;
        bad = -1;
        n_checks++;
        for (int i = 259; i >= 0; i--)
            if (act[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: entry %0d got %04h expected %04h at %0t",
                     nm, bad, act[bad*16 +: 16], exp[bad*16 +: 16], $time);
        end
    endtask

    // Pixel list of a line from integer Bresenham arithmetic
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int ddx, ddy, sx, sy, err, e2, cx, cy;
        ddx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ddy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = ddx + ddy;
        cx  = ax0;
        cy  = ay0;
        mn  = 0;
        for (int i = 0; i < 256; i++) begin
            mpts[mn] = {cx[7:0], cy[7:0]};
            mn++;
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * err;
            if (e2 >= ddy) begin err += ddy; cx += sx; end
            if (e2 <= ddx) begin err += ddx; cy += sy; end
        end
    endtask

    // Compare process: advance the model on rising edges, check on falling edges
    initial begin
        forever begin
            @(posedge clk);
            if (!n_rst) mstate = 0;
            else if (start && (mstate == 0 || k >= mn + 1)) begin
                build_model(int'(tx0), int'(ty0), int'(tx1), int'(ty1));
                mstate = 1;
                k = 0;
            end else if (mstate == 1) k++;

            @(negedge clk);
            if (!n_rst) mstate = 0;
            if (mstate == 0) begin
                chk("idle_x", x, 0);
                chk("idle_y", y, 0);
                chk("idle_done", done, 0);
                chkbuf("idle_buf", lb, '0);
`ifdef BRESENHAM_PIXEL_VALID_EN
                chk("idle_pv", pv, 0);
`endif
            end else begin
                nw = (k < 1) ? 0 : ((k - 1 > mn) ? mn : k - 1);
                eb = '0;
                for (int i = 0; i < nw; i++) eb[i*16 +: 16] = mpts[i];
                chkbuf("model_buf", lb, eb);
                chk("model_done", done, (k >= mn + 2) ? 1 : 0);
                if (k >= 1) begin
                    chk("model_x", x, mpts[(k <= mn) ? k - 1 : mn - 1][15:8]);
                    chk("model_y", y, mpts[(k <= mn) ? k - 1 : mn - 1][7:0]);
                end
`ifdef BRESENHAM_PIXEL_VALID_EN
                chk("model_pv", pv, (k >= 1 && k <= mn) ? 1 : 0);
`endif
            end
        end
    end

    // Issue one line request and count edges from the sampling edge until done
    task automatic run_line(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input int pulse_at, output int edges);
        @(posedge clk); #1;
        tx0 = a; ty0 = b; tx1 = c; ty1 = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs are scrambled after sampling; they must have no effect
        tx0 = ~a; ty0 = ~b; tx1 = 8'h5A; ty1 = 8'hC3;
        edges = 0;
        while (edges < 400) begin
            @(posedge clk);
            edges++;
            #1;
            start = (pulse_at > 0) && (edges == pulse_at || edges == pulse_at + 70);
            if (done) break;
        end
        start = 1'b0;
        chk("done_reached", done, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        logic [15:0] ex [5];

        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Horizontal line
        run_line(8'd0, 8'd0, 8'd3, 8'd0, 0, e);
        chk("hz_edges", e, 6);
        chk("hz_entries", lb[63:0], 64'h0300_0200_0100_0000);
        chk("hz_upper_zero", |lb[4159:64], 0);

        // Shallow line
        run_line(8'd0, 8'd0, 8'd4, 8'd2, 0, e);
        ex = '{16'h0000, 16'h0101, 16'h0201, 16'h0302, 16'h0402};
        for (int i = 0; i < 5; i++) chk("shallow_entry", lb[i*16 +: 16], ex[i]);
        chk("shallow_x", x, 4);
        chk("shallow_y", y, 2);
        chk("shallow_done", done, 1);

        // Steep line with x decreasing
        run_line(8'd10, 8'd0, 8'd8, 8'd4, 0, e);
        ex = '{16'h0A00, 16'h0901, 16'h0902, 16'h0803, 16'h0804};
        for (int i = 0; i < 5; i++) chk("steep_entry", lb[i*16 +: 16], ex[i]);

        // Other octants
        run_line(8'd20, 8'd10, 8'd13, 8'd13, 0, e);
        chk("oct_a_edges", e, 10);
        run_line(8'd3, 8'd9, 8'd5, 8'd2, 0, e);
        chk("oct_b_edges", e, 10);
        chk("oct_b_end", {x, y}, 16'h0502);

        // Degenerate line, then restart from DONE
        run_line(8'd7, 8'd7, 8'd7, 8'd7, 0, e);
        chk("degen_edges", e, 3);
        chk("degen_entry", lb[15:0], 16'h0707);
        chk("degen_upper_zero", |lb[4159:16], 0);
        run_line(8'd5, 8'd5, 8'd2, 8'd5, 0, e);
        chk("restart_edges", e, 6);
        chk("restart_entries", lb[63:0], 64'h0205_0305_0405_0505);
        chk("restart_upper_zero", |lb[4159:64], 0);

        // Maximum-length diagonal with stray start pulses during DRAW
        run_line(8'd0, 8'd0, 8'd255, 8'd255, 50, e);
        chk("max_edges", e, 258);
        chk("max_last_entry", lb[4095:4080], 16'hFFFF);
        chk("max_mid_entry", lb[2063:2048], 16'h8080);
        chk("max_upper_zero", |lb[4159:4096], 0);

        // Asynchronous reset in the middle of a line
        @(posedge clk); #1;
        tx0 = 8'd0; ty0 = 8'd0; tx1 = 8'd100; ty1 = 8'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk("rst_pre_x", x, 19);
        n_rst = 1'b0;
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_done", done, 0);
        chk("rst_buf", |lb, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        run_line(8'd1, 8'd1, 8'd2, 8'd2, 0, e);
        chk("post_rst_edges", e, 4);
        chk("post_rst_entries", lb[31:0], 32'h0202_0101);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
